// File: rtl/toy_ldu_wb_pkg.sv
// Shared types and constants for the load writeback stage (toy_ldu_wb).
// ldu_pkg is the packet produced by the toy_ldu decode stage. ldu_wb_pkg is
// the packet handed to the register-file/commit arbiter. The misalign bit in
// ldu_wb_pkg is always present. It is driven only when
// TOY_LDU_WB_MISALIGN_CHK_EN is defined; otherwise it is tied to 0.
package toy_ldu_wb_pkg;

  localparam int LDU_ADDR_W   = 32;
  localparam int LDU_DATA_W   = 32;
  localparam int LSID_W       = 4;
  localparam int INST_ID_W    = 8;
  localparam int ARCH_IDX_W   = 6;
  localparam int LDU_WB_DEPTH = 4;
  localparam int OFFSET_WIDTH = 2;

  // RV32 load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [LDU_ADDR_W-1:0] mem_req_addr;
    logic [3:0]            mem_req_strb;
    logic [2:0]            funct3;
    logic [LSID_W-1:0]     lsid;
    logic [4:0]            inst_rd;
    logic                  inst_rd_en;
    logic                  inst_fp_rd_en;
    logic [LDU_ADDR_W-1:0] inst_pc;
    logic [INST_ID_W-1:0]  inst_id;
    logic [ARCH_IDX_W-1:0] arch_reg_index;
    logic                  c_ext;
  } ldu_pkg;

  typedef struct packed {
    logic [LDU_DATA_W-1:0] reg_val;
    logic [4:0]            inst_rd;
    logic                  inst_rd_en;
    logic                  inst_fp_rd_en;
    logic [ARCH_IDX_W-1:0] arch_reg_index;
    logic [LSID_W-1:0]     lsid;
    logic [INST_ID_W-1:0]  inst_id;
    logic [LDU_ADDR_W-1:0] inst_pc;
    logic                  c_ext;
    logic                  misalign;
  } ldu_wb_pkg;

  // Per-entry metadata kept while a load is outstanding
  typedef struct packed {
    logic [LSID_W-1:0]       lsid;
    logic [4:0]              inst_rd;
    logic                    inst_rd_en;
    logic                    inst_fp_rd_en;
    logic [LDU_ADDR_W-1:0]   inst_pc;
    logic [INST_ID_W-1:0]    inst_id;
    logic [ARCH_IDX_W-1:0]   arch_reg_index;
    logic                    c_ext;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [2:0]              funct3;
  } ldu_wb_ent_t;

  // Halfword loads need an even address, word loads a word-aligned one
  function automatic logic is_misalign(input logic [2:0] f3,
                                       input logic [OFFSET_WIDTH-1:0] off);
    logic m;
    m = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) m = off[0];
    else if (f3 == F3_LW)                m = |off;
    return m;
  endfunction

endpackage

// File: rtl/toy_ldu_wb_extract.sv
// Purely combinational load data extraction. It shifts the returned word down
// by the byte offset, then sign- or zero-extends it according to funct3.
module toy_ldu_wb_extract
  import toy_ldu_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [2:0]              funct3,
  output logic [DATA_WIDTH-1:0]   val
);

  logic [DATA_WIDTH-1:0] shifted;

  // Align the addressed byte/halfword to bit 0, then extend per funct3
  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (funct3)
      F3_LB:   val = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  val = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LH:   val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: val = data;
    endcase
  end

endmodule

// File: rtl/toy_ldu_wb.sv
// Load response / writeback stage. It issues memory reads for decoded loads
// and tracks up to DEPTH outstanding loads in order. Acks are captured into
// the tracking entries, and the extracted data at the head is presented as a
// writeback packet.
// Optional: TOY_LDU_WB_MISALIGN_CHK_EN flags misaligned LH/LHU/LW loads and
// forces their reg_val to 0.
module toy_ldu_wb
  import toy_ldu_wb_pkg::*;
#(
  parameter int DEPTH      = LDU_WB_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_load_vld,
  input  ldu_pkg                s_load_pld,
  output logic                  s_load_rdy,
  output logic                  m_mem_req_vld,
  input  logic                  m_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] m_mem_req_addr,
  output logic [3:0]            m_mem_req_strb,
  input  logic                  s_mem_ack_vld,
  input  logic [DATA_WIDTH-1:0] s_mem_ack_data,
  output logic                  m_wb_vld,
  input  logic                  m_wb_rdy,
  output ldu_wb_pkg             m_wb_pld
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr, ack_ptr, rd_ptr;
  logic [PW:0]   count;    // entries allocated
  logic [PW:0]   unacked;  // entries still waiting for their ack

  ldu_wb_ent_t           meta_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      data_vld_q;
`ifdef TOY_LDU_WB_MISALIGN_CHK_EN
  logic [DEPTH-1:0]      misalign_q;
`endif

  logic full, empty, enq, pop, ack;
  logic [DATA_WIDTH-1:0] ext_val;
  ldu_wb_ent_t           head;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // Request path is fully combinational; upstream sees the memory's ready
  assign m_mem_req_vld  = s_load_vld & ~full;
  assign s_load_rdy     = m_mem_req_rdy & ~full;
  assign m_mem_req_addr = {s_load_pld.mem_req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign m_mem_req_strb = s_load_pld.mem_req_strb << s_load_pld.mem_req_addr[1:0];

  assign enq = s_load_vld & s_load_rdy;
  // An ack with nothing pending is dropped rather than corrupting an entry
  assign ack = s_mem_ack_vld & (unacked != '0);
  assign pop = m_wb_vld & m_wb_rdy;

  assign head     = meta_q[rd_ptr];
  assign m_wb_vld = ~empty & data_vld_q[rd_ptr];

  // Pointers, occupancy and data-valid flags; these alone define queue state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      ack_ptr    <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      unacked    <= '0;
      data_vld_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      // ack and pop always touch different entries: pop needs data_vld set,
      // ack targets an entry that has not been acked yet
      if (ack) begin
        ack_ptr             <= ack_ptr + 1'b1;
        data_vld_q[ack_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr             <= rd_ptr + 1'b1;
        data_vld_q[rd_ptr] <= 1'b0;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({enq, ack})
        2'b10:   unacked <= unacked + 1'b1;
        2'b01:   unacked <= unacked - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry payload; valid flags gate every use, so no reset is needed here
  always_ff @(posedge clk) begin
    if (enq) begin
      meta_q[wr_ptr].lsid           <= s_load_pld.lsid;
      meta_q[wr_ptr].inst_rd        <= s_load_pld.inst_rd;
      meta_q[wr_ptr].inst_rd_en     <= s_load_pld.inst_rd_en;
      meta_q[wr_ptr].inst_fp_rd_en  <= s_load_pld.inst_fp_rd_en;
      meta_q[wr_ptr].inst_pc        <= s_load_pld.inst_pc;
      meta_q[wr_ptr].inst_id        <= s_load_pld.inst_id;
      meta_q[wr_ptr].arch_reg_index <= s_load_pld.arch_reg_index;
      meta_q[wr_ptr].c_ext          <= s_load_pld.c_ext;
      meta_q[wr_ptr].offset         <= s_load_pld.mem_req_addr[OFFSET_WIDTH-1:0];
      meta_q[wr_ptr].funct3         <= s_load_pld.funct3;
`ifdef TOY_LDU_WB_MISALIGN_CHK_EN
      misalign_q[wr_ptr] <= is_misalign(s_load_pld.funct3,
                                        s_load_pld.mem_req_addr[OFFSET_WIDTH-1:0]);
`endif
    end
    if (ack) data_q[ack_ptr] <= s_mem_ack_data;
  end

  toy_ldu_wb_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
    .data   (data_q[rd_ptr]),
    .offset (head.offset),
    .funct3 (head.funct3),
    .val    (ext_val)
  );

  // Writeback packet straight from the head entry
  always_comb begin
    m_wb_pld                = '0;
    m_wb_pld.reg_val        = ext_val;
    m_wb_pld.inst_rd        = head.inst_rd;
    m_wb_pld.inst_rd_en     = head.inst_rd_en;
    m_wb_pld.inst_fp_rd_en  = head.inst_fp_rd_en;
    m_wb_pld.arch_reg_index = head.arch_reg_index;
    m_wb_pld.lsid           = head.lsid;
    m_wb_pld.inst_id        = head.inst_id;
    m_wb_pld.inst_pc        = head.inst_pc;
    m_wb_pld.c_ext          = head.c_ext;
`ifdef TOY_LDU_WB_MISALIGN_CHK_EN
    m_wb_pld.misalign = misalign_q[rd_ptr];
    if (misalign_q[rd_ptr]) m_wb_pld.reg_val = '0;
`endif
  end

  // Acks arrive strictly for issued requests
  a_ack_has_pending: assert property (@(posedge clk) disable iff (!rst_n)
    s_mem_ack_vld |-> (unacked != '0));

endmodule

// File: tb/tb_toy_ldu_wb.sv
// Directed bench for toy_ldu_wb. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_toy_ldu_wb;
  import toy_ldu_wb_pkg::*;

  logic        clk, rst_n;
  logic        s_load_vld, s_load_rdy;
  ldu_pkg      s_load_pld;
  logic        m_mem_req_vld, m_mem_req_rdy;
  logic [31:0] m_mem_req_addr;
  logic [3:0]  m_mem_req_strb;
  logic        s_mem_ack_vld;
  logic [31:0] s_mem_ack_data;
  logic        m_wb_vld, m_wb_rdy;
  ldu_wb_pkg   m_wb_pld;

  int checks = 0;
  int errors = 0;

  toy_ldu_wb dut (
    .clk(clk), .rst_n(rst_n),
    .s_load_vld(s_load_vld), .s_load_pld(s_load_pld), .s_load_rdy(s_load_rdy),
    .m_mem_req_vld(m_mem_req_vld), .m_mem_req_rdy(m_mem_req_rdy),
    .m_mem_req_addr(m_mem_req_addr), .m_mem_req_strb(m_mem_req_strb),
    .s_mem_ack_vld(s_mem_ack_vld), .s_mem_ack_data(s_mem_ack_data),
    .m_wb_vld(m_wb_vld), .m_wb_rdy(m_wb_rdy), .m_wb_pld(m_wb_pld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ldu_pkg mk(input logic [31:0] addr, input logic [3:0] strb,
                                input logic [2:0] f3, input logic [3:0] lsid);
    ldu_pkg p;
    p                = '0;
    p.mem_req_addr   = addr;
    p.mem_req_strb   = strb;
    p.funct3         = f3;
    p.lsid           = lsid;
    p.inst_rd        = {1'b0, lsid};
    p.inst_rd_en     = 1'b1;
    p.inst_pc        = 32'h8000_0000 | {28'h0, lsid};
    p.inst_id        = {4'h0, lsid};
    p.arch_reg_index = {2'b00, lsid};
    return p;
  endfunction

  localparam int N = 8;

  initial begin
    rst_n = 1'b0; s_load_vld = 1'b0; s_load_pld = '0; m_mem_req_rdy = 1'b1;
    s_mem_ack_vld = 1'b0; s_mem_ack_data = '0; m_wb_rdy = 1'b0;

    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst_wb_vld", 32'(m_wb_vld), 32'd0);
    chk("rst_req_vld", 32'(m_mem_req_vld), 32'd0);
    chk("rst_load_rdy_hi", 32'(s_load_rdy), 32'd1);
    m_mem_req_rdy = 1'b0; #1;
    chk("rst_load_rdy_lo", 32'(s_load_rdy), 32'd0);
    m_mem_req_rdy = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    // ---- LB at 0x1003, ack 0x80FF_1234
    @(negedge clk);
    s_load_vld = 1'b1; s_load_pld = mk(32'h1003, 4'h1, F3_LB, 4'd1); #1;
    chk("lb_req_vld", 32'(m_mem_req_vld), 32'd1);
    chk("lb_req_addr", m_mem_req_addr, 32'h1000);
    chk("lb_req_strb", 32'(m_mem_req_strb), 32'h8);
    @(negedge clk);
    s_load_vld = 1'b0; s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'h80FF_1234; #1;
    chk("lb_wb_not_yet", 32'(m_wb_vld), 32'd0);
    @(negedge clk);
    s_mem_ack_vld = 1'b0; m_wb_rdy = 1'b1; #1;
    chk("lb_wb_vld", 32'(m_wb_vld), 32'd1);
    chk("lb_reg_val", m_wb_pld.reg_val, 32'hFFFF_FF80);
    chk("lb_lsid", 32'(m_wb_pld.lsid), 32'd1);
    chk("lb_pc", m_wb_pld.inst_pc, 32'h8000_0001);
`ifdef TOY_LDU_WB_MISALIGN_CHK_EN
    chk("lb_misalign", 32'(m_wb_pld.misalign), 32'd0);
`endif
    @(negedge clk);
    m_wb_rdy = 1'b0; #1;
    chk("lb_popped", 32'(m_wb_vld), 32'd0);

    // ---- LHU then LH at 0x2002, both acked with 0xBEEF_0000
    @(negedge clk);
    s_load_vld = 1'b1; s_load_pld = mk(32'h2002, 4'h3, F3_LHU, 4'd2); #1;
    chk("lhu_req_addr", m_mem_req_addr, 32'h2000);
    chk("lhu_req_strb", 32'(m_mem_req_strb), 32'hC);
    @(negedge clk);
    s_load_pld = mk(32'h2002, 4'h3, F3_LH, 4'd3);
    s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'hBEEF_0000;
    @(negedge clk);
    s_load_vld = 1'b0; m_wb_rdy = 1'b1; #1;
    chk("lhu_wb_vld", 32'(m_wb_vld), 32'd1);
    chk("lhu_reg_val", m_wb_pld.reg_val, 32'h0000_BEEF);
    chk("lhu_lsid", 32'(m_wb_pld.lsid), 32'd2);
    @(negedge clk);
    s_mem_ack_vld = 1'b0; #1;
    chk("lh_wb_vld", 32'(m_wb_vld), 32'd1);
    chk("lh_reg_val", m_wb_pld.reg_val, 32'hFFFF_BEEF);
    chk("lh_lsid", 32'(m_wb_pld.lsid), 32'd3);
    @(negedge clk);
    m_wb_rdy = 1'b0; #1;
    chk("lh_popped", 32'(m_wb_vld), 32'd0);

    // ---- fill the queue with 4 LWs while writeback is stalled
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_load_vld = 1'b1; s_load_pld = mk(32'h4000 + 32'(4*i), 4'hF, F3_LW, 4'(4+i));
      s_mem_ack_vld = (i > 0); s_mem_ack_data = 32'hA000_0000 | 32'(i-1); #1;
      chk("fill_load_rdy", 32'(s_load_rdy), 32'd1);
    end
    @(negedge clk);
    s_load_pld = mk(32'h4010, 4'hF, F3_LW, 4'd8);
    s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'hA000_0003; #1;
    chk("full_load_rdy", 32'(s_load_rdy), 32'd0);
    chk("full_req_vld", 32'(m_mem_req_vld), 32'd0);
    @(negedge clk);
    s_load_vld = 1'b0; s_mem_ack_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_hold_rdy", 32'(s_load_rdy), 32'd0);
    chk("full_count", 32'(dut.count), 32'd4);
    m_wb_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain_vld", 32'(m_wb_vld), 32'd1);
      chk("drain_lsid", 32'(m_wb_pld.lsid), 32'(4+j));
      chk("drain_val", m_wb_pld.reg_val, 32'hA000_0000 | 32'(j));
      @(negedge clk);
    end
    #1;
    chk("drain_empty", 32'(m_wb_vld), 32'd0);
    chk("drain_load_rdy", 32'(s_load_rdy), 32'd1);

    // ---- memory ready toggling 1,0,1 under continuous valid
    @(negedge clk);
    s_load_vld = 1'b1; s_load_pld = mk(32'h5000, 4'hF, F3_LW, 4'd9); m_mem_req_rdy = 1'b1; #1;
    chk("tog_rdy0", 32'(s_load_rdy), 32'd1);
    @(negedge clk);
    s_load_pld = mk(32'h5004, 4'hF, F3_LW, 4'd10); m_mem_req_rdy = 1'b0;
    s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'h9; #1;
    chk("tog_rdy1", 32'(s_load_rdy), 32'd0);
    chk("tog_req_vld1", 32'(m_mem_req_vld), 32'd1);
    @(negedge clk);
    m_mem_req_rdy = 1'b1; s_mem_ack_vld = 1'b0; #1;
    chk("tog_rdy2", 32'(s_load_rdy), 32'd1);
    chk("tog_wb9_vld", 32'(m_wb_vld), 32'd1);
    chk("tog_wb9_lsid", 32'(m_wb_pld.lsid), 32'd9);
    @(negedge clk);
    s_load_vld = 1'b0; s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'hA; #1;
    chk("tog_gap", 32'(m_wb_vld), 32'd0);
    @(negedge clk);
    s_mem_ack_vld = 1'b0; #1;
    chk("tog_wb10_vld", 32'(m_wb_vld), 32'd1);
    chk("tog_wb10_lsid", 32'(m_wb_pld.lsid), 32'd10);
    chk("tog_wb10_val", m_wb_pld.reg_val, 32'hA);
    @(negedge clk); #1;
    chk("tog_done_vld", 32'(m_wb_vld), 32'd0);
    chk("tog_done_count", 32'(dut.count), 32'd0);

    // ---- steady stream: enqueue, ack and pop every cycle
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      s_load_vld = (k < N);
      s_load_pld = mk(32'h6000 + 32'(4*k), 4'hF, F3_LW, 4'(k));
      s_mem_ack_vld = (k >= 1) && (k <= N);
      s_mem_ack_data = 32'hC000_0000 | 32'(k-1); #1;
      if (k >= 2) begin
        chk("stream_vld", 32'(m_wb_vld), 32'd1);
        chk("stream_lsid", 32'(m_wb_pld.lsid), 32'(4'(k-2)));
        chk("stream_val", m_wb_pld.reg_val, 32'hC000_0000 | 32'(k-2));
      end
      if (k >= 2 && k <= N) chk("stream_count", 32'(dut.count), 32'd2);
    end
    @(negedge clk);
    s_mem_ack_vld = 1'b0; #1;
    chk("stream_end_vld", 32'(m_wb_vld), 32'd0);
    chk("stream_end_count", 32'(dut.count), 32'd0);
    m_wb_rdy = 1'b0;

    // ---- reset with 3 outstanding, 1 acked
    @(negedge clk);
    s_load_vld = 1'b1; s_load_pld = mk(32'h7100, 4'hF, F3_LW, 4'd1);
    @(negedge clk);
    s_load_pld = mk(32'h7104, 4'hF, F3_LW, 4'd2);
    s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'h11;
    @(negedge clk);
    s_load_pld = mk(32'h7108, 4'hF, F3_LW, 4'd3); s_mem_ack_vld = 1'b0;
    @(negedge clk);
    s_load_vld = 1'b0; #1;
    chk("prerst_wb_vld", 32'(m_wb_vld), 32'd1);
    chk("prerst_count", 32'(dut.count), 32'd3);
    rst_n = 1'b0; #1;
    chk("midrst_wb_vld", 32'(m_wb_vld), 32'd0);
    chk("midrst_count", 32'(dut.count), 32'd0);
    chk("midrst_load_rdy", 32'(s_load_rdy), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    s_load_vld = 1'b1; s_load_pld = mk(32'h7000, 4'hF, F3_LW, 4'd5); #1;
    chk("postrst_load_rdy", 32'(s_load_rdy), 32'd1);
    @(negedge clk);
    s_load_vld = 1'b0; s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'h1234_5678; #1;
    chk("postrst_no_stale", 32'(m_wb_vld), 32'd0);
    @(negedge clk);
    s_mem_ack_vld = 1'b0; m_wb_rdy = 1'b1; #1;
    chk("postrst_wb_vld", 32'(m_wb_vld), 32'd1);
    chk("postrst_val", m_wb_pld.reg_val, 32'h1234_5678);
    chk("postrst_lsid", 32'(m_wb_pld.lsid), 32'd5);
    @(negedge clk);
    m_wb_rdy = 1'b0; #1;
    chk("postrst_empty", 32'(m_wb_vld), 32'd0);

`ifdef TOY_LDU_WB_MISALIGN_CHK_EN
    // ---- misaligned LW is issued and retires with misalign=1, reg_val=0
    @(negedge clk);
    s_load_vld = 1'b1; s_load_pld = mk(32'h3001, 4'hF, F3_LW, 4'd14); #1;
    chk("mis_req_vld", 32'(m_mem_req_vld), 32'd1);
    chk("mis_req_addr", m_mem_req_addr, 32'h3000);
    @(negedge clk);
    s_load_vld = 1'b0; s_mem_ack_vld = 1'b1; s_mem_ack_data = 32'hDEAD_BEEF;
    @(negedge clk);
    s_mem_ack_vld = 1'b0; m_wb_rdy = 1'b1; #1;
    chk("mis_wb_vld", 32'(m_wb_vld), 32'd1);
    chk("mis_flag", 32'(m_wb_pld.misalign), 32'd1);
    chk("mis_reg_val", m_wb_pld.reg_val, 32'd0);
    @(negedge clk);
    m_wb_rdy = 1'b0;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toy_ldu_wb.md
Name: toy_ldu_wb

Overview:
- Load response/writeback stage directly downstream of the load decode stage (toy_ldu); consumes its ldu_pkg.
- Issues the memory read request and tracks up to DEPTH outstanding loads in order.
- Captures ack data, then byte-aligns and sign/zero-extends it per funct3.
- Presents a writeback packet to the register-file/commit arbiter with a valid/ready handshake.

Parameters:
- DEPTH, 4, outstanding-load tracking entries; power of two, ≥2.
- ADDR_WIDTH, 32, memory address width (toy_pack value).
- DATA_WIDTH, 32, bus/register data width; fixed 32 for RV32.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- s_load_vld  in  1  load packet valid from the decode stage.
- s_load_pld  in  ldu_pkg  load packet: mem_req_addr, mem_req_strb, funct3, lsid, inst_rd, inst_rd_en, inst_fp_rd_en, inst_pc, inst_id, arch_reg_index, c_ext.
- s_load_rdy  out  1  packet accepted when vld&rdy.
- m_mem_req_vld  out  1  memory read request valid.
- m_mem_req_rdy  in  1  memory accepts request.
- m_mem_req_addr  out  ADDR_WIDTH  word-aligned address: {addr[ADDR_WIDTH-1:2],2'b00}.
- m_mem_req_strb  out  4  byte strobe, pld strb shifted left by addr[1:0].
- s_mem_ack_vld  in  1  read data returned, in request order; no backpressure.
- s_mem_ack_data  in  DATA_WIDTH  returned word.
- m_wb_vld  out  1  writeback valid.
- m_wb_rdy  in  1  writeback accepted.
- m_wb_pld  out  ldu_wb_pkg  reg_val, inst_rd, inst_rd_en, inst_fp_rd_en, arch_reg_index, lsid, inst_id, inst_pc, c_ext.

Behaviour:
- Request path is combinational:
  - m_mem_req_vld = s_load_vld & ~full.
  - s_load_rdy = m_mem_req_rdy & ~full.
  - Enqueue when s_load_vld & s_load_rdy.
- Queue entry stores metadata, byte offset addr[1:0], funct3, a data register and a data_vld flag.
- Pointers and count:
  - wr_ptr, ack_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Ack handling:
  - On s_mem_ack_vld with count>ack-pending, the entry at ack_ptr captures the data, sets data_vld and advances ack_ptr.
  - An ack arriving with no pending request is dropped; an SVA fires under simulation.
- Writeback handshake:
  - m_wb_vld = ~empty & entry[rd_ptr].data_vld.
  - m_wb_pld is driven combinationally from the head entry.
  - Pop on m_wb_vld & m_wb_rdy: clears data_vld and advances rd_ptr.
- Timing:
  - Earliest writeback is the cycle after the ack (registered data), so minimum load-to-writeback latency is 2 cycles after the request handshake, assuming a 1-cycle memory.
  - Throughput is one load per cycle when there is no stall.
- Extraction: shifted = ack_data >> (8*offset).
  - LB: {{24{shifted[7]}}, shifted[7:0]}.
  - LBU: zero-extended shifted[7:0].
  - LH: sign-extended shifted[15:0].
  - LHU: zero-extended shifted[15:0].
  - LW and default: ack_data unshifted.
- Loads with inst_rd_en=0 and inst_fp_rd_en=0 still produce a writeback, so the lsid retires; reg_val is don't-care.
- Simultaneous events:
  - Enqueue and pop in the same cycle leave count unchanged.
  - An ack may target the head entry in the same cycle the previous head pops; there is no conflict because entries are distinct.
  - Enqueue while full is impossible, since rdy=0.
- Reset:
  - Asynchronous; clears pointers, count and all data_vld flags.
  - m_wb_vld=0, m_mem_req_vld=0 while s_load_vld=0, s_load_rdy follows m_mem_req_rdy.
  - Mid-operation reset drops all in-flight loads; the upstream flush is responsible for them.
- Entry data and metadata registers are not reset.

Optional Feature:
- Macro: TOY_LDU_WB_MISALIGN_CHK_EN.
- With the macro defined:
  - Misaligned requests (LH/LHU with addr[0]=1; LW with addr[1:0]!=0) are still enqueued and issued.
  - The entry records misalign=1 and the writeback pld field misalign is driven.
  - reg_val=0 for that entry.
- Without the macro: no misalign field logic; reg_val uses the same extraction, with the upper bytes holding whatever the shift produces.

Decomposition:
- toy_pack additions: ldu_wb_pkg typedef (including the misalign bit, tied 0 when the feature is off), plus LDU_WB_DEPTH and OFFSET_WIDTH=2 constants.
- The F3_* encodings already exist there.
- One sub-module, toy_ldu_wb_extract: purely combinational funct3/offset shift and extend, unit-testable alone.
- Queue control stays in toy_ldu_wb.

Test Plan:
- LB at addr 0x1003, ack 0x80FF_1234 → req addr 0x1000, strb 4'h8; wb reg_val 0xFFFF_FF80, at the cycle after the ack.
- LHU at 0x2002, ack 0xBEEF_0000 → strb 4'hC, reg_val 0x0000_BEEF; LH with the same ack → 0xFFFF_BEEF.
- Issue 4 LWs back-to-back with m_wb_rdy=0 and acks returned → s_load_rdy=0 after the 4th; hold m_wb_rdy low, then release → 4 writebacks in lsid order, then s_load_rdy=1.
- m_mem_req_rdy toggling 1,0,1 with continuous s_load_vld → exactly one enqueue per rdy-high cycle; no duplicate or lost lsid.
- Steady stream: ack every cycle, m_wb_rdy=1 → enqueue and pop in the same cycle, count stays constant, one writeback per cycle.
- Assert rst_n low with 3 outstanding and 1 acked → m_wb_vld=0 immediately, count=0; after release, a new LW completes normally.
- With TOY_LDU_WB_MISALIGN_CHK_EN defined: LW at 0x3001 → wb misalign=1, reg_val=0.
